// File: rtl/gshare_btb_predictor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gshare_btb_predictor                                       |
// | Description : Branch prediction unit for the RV32IM fetch stage. An      |
// |               N-way set-associative BTB supplies targets and a gshare    |
// |               table (PC XOR global history) supplies direction. The GHR  |
// |               shifts speculatively on every BTB-hit lookup and is        |
// |               repaired from the pipeline snapshot on a mispredict.       |
// |               Saturating lookup/mispredict counters are provided.        |
// | Option      : define BP_RAS_EN to add per-entry branch type bits and a   |
// |               return address stack used to predict returns.             |
// | Ports       : clk_i, rst_ni (async, active-low)                          |
// |               pred_valid_i, pc_i -> predict_taken_o, predict_target_o,   |
// |               btb_hit_o, ghr_snapshot_o (combinational lookup)          |
// |               update_i, update_pc_i, update_ghr_i, actual_taken_i,      |
// |               actual_target_i, mispredict_i, is_call_i, is_return_i     |
// |               lookup_count_o, mispredict_count_o                        |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module gshare_btb_predictor #(
   parameter int ADDR_WIDTH  = 32,
   parameter int BTB_SETS    = 32,
   parameter int BTB_WAYS    = 2,
   parameter int BHT_ENTRIES = 256,
   parameter int GHR_WIDTH   = 8,
   parameter int RAS_DEPTH   = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  pred_valid_i,
   input  logic [ADDR_WIDTH-1:0] pc_i,
   output logic                  predict_taken_o,
   output logic [ADDR_WIDTH-1:0] predict_target_o,
   output logic                  btb_hit_o,
   output logic [GHR_WIDTH-1:0]  ghr_snapshot_o,
   input  logic                  update_i,
   input  logic [ADDR_WIDTH-1:0] update_pc_i,
   input  logic [GHR_WIDTH-1:0]  update_ghr_i,
   input  logic                  actual_taken_i,
   input  logic [ADDR_WIDTH-1:0] actual_target_i,
   input  logic                  mispredict_i,
   input  logic                  is_call_i,
   input  logic                  is_return_i,
   output logic [31:0]           lookup_count_o,
   output logic [31:0]           mispredict_count_o
);

   localparam int c_set_bits = $clog2(BTB_SETS);
   localparam int c_bht_bits = $clog2(BHT_ENTRIES);
   localparam int c_way_bits = (BTB_WAYS > 1) ? $clog2(BTB_WAYS) : 1;
   localparam int c_tag_w    = ADDR_WIDTH - c_set_bits - 2;
   localparam logic [ADDR_WIDTH-1:0] c_four = ADDR_WIDTH'(4);
   localparam logic [c_way_bits-1:0] c_last_way = c_way_bits'(BTB_WAYS - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic                  r_valid  [BTB_SETS][BTB_WAYS];
   logic [c_tag_w-1:0]    r_tag    [BTB_SETS][BTB_WAYS];
   logic [ADDR_WIDTH-1:0] r_target [BTB_SETS][BTB_WAYS];
   logic [c_way_bits-1:0] r_rr     [BTB_SETS];
   logic [1:0]            r_bht    [BHT_ENTRIES];
   logic [GHR_WIDTH-1:0]  r_ghr;
   logic [31:0]           r_lookup_cnt;
   logic [31:0]           r_misp_cnt;

   // ------------------------------------------------------------------
   // Lookup side (combinational, reads pre-update state)
   // ------------------------------------------------------------------
   logic [c_set_bits-1:0] w_set;
   logic [c_tag_w-1:0]    w_tag;
   logic [c_bht_bits-1:0] w_bht_idx;
   logic [BTB_WAYS-1:0]   w_hit_vec;
   logic [c_way_bits-1:0] w_hit_way;
   logic                  w_hit;
   logic                  w_taken;
   logic [ADDR_WIDTH-1:0] w_target;
   logic [ADDR_WIDTH-1:0] w_pc_plus4;

   assign w_set      = pc_i[c_set_bits+1:2];
   assign w_tag      = pc_i[ADDR_WIDTH-1:c_set_bits+2];
   assign w_bht_idx  = pc_i[c_bht_bits+1:2] ^ r_ghr[c_bht_bits-1:0];
   assign w_pc_plus4 = pc_i + c_four;

   // ------------------------------------------------------------------
   // Update side
   // ------------------------------------------------------------------
   logic [c_set_bits-1:0] w_upd_set;
   logic [c_tag_w-1:0]    w_upd_tag;
   logic [c_bht_bits-1:0] w_upd_bht_idx;
   logic [BTB_WAYS-1:0]   w_upd_hit_vec;
   logic [c_way_bits-1:0] w_upd_hit_way;
   logic                  w_upd_hit;
   logic [c_way_bits-1:0] w_victim;
   logic                  w_has_invalid;
   logic [c_way_bits-1:0] w_upd_way;
   logic                  w_btb_write;
   logic                  w_rr_advance;

   assign w_upd_set     = update_pc_i[c_set_bits+1:2];
   assign w_upd_tag     = update_pc_i[ADDR_WIDTH-1:c_set_bits+2];
   assign w_upd_bht_idx = update_pc_i[c_bht_bits+1:2] ^ update_ghr_i[c_bht_bits-1:0];

   for (genvar w = 0; w < BTB_WAYS; w++) begin : g_way_match
      assign w_hit_vec[w]     = r_valid[w_set][w] && (r_tag[w_set][w] == w_tag);
      assign w_upd_hit_vec[w] = r_valid[w_upd_set][w] && (r_tag[w_upd_set][w] == w_upd_tag);
   end

   assign w_hit     = |w_hit_vec;
   assign w_upd_hit = |w_upd_hit_vec;

   // At most one way matches, so a priority encoder is a plain one-hot decode.
   always_comb begin
      w_hit_way     = '0;
      w_upd_hit_way = '0;
      for (int w = 0; w < BTB_WAYS; w++) begin
         if (w_hit_vec[w])     w_hit_way     = c_way_bits'(w);
         if (w_upd_hit_vec[w]) w_upd_hit_way = c_way_bits'(w);
      end
   end

   // Victim: lowest-index invalid way; scanning downward lets the lowest win.
   always_comb begin
      w_victim      = r_rr[w_upd_set];
      w_has_invalid = 1'b0;
      for (int w = BTB_WAYS - 1; w >= 0; w--) begin
         if (!r_valid[w_upd_set][w]) begin
            w_victim      = c_way_bits'(w);
            w_has_invalid = 1'b1;
         end
      end
   end

   // Replacement is purely round-robin, so a hit needs no recency state.
   assign w_upd_way    = w_upd_hit ? w_upd_hit_way : w_victim;
   assign w_btb_write  = update_i && (w_upd_hit || actual_taken_i);
   assign w_rr_advance = update_i && !w_upd_hit && actual_taken_i && !w_has_invalid;

`ifdef BP_RAS_EN
   localparam int         c_ras_bits    = $clog2(RAS_DEPTH);
   localparam logic [1:0] c_type_branch = 2'b00;
   localparam logic [1:0] c_type_call   = 2'b01;
   localparam logic [1:0] c_type_return = 2'b10;

   logic [1:0]            r_type    [BTB_SETS][BTB_WAYS];
   logic [ADDR_WIDTH-1:0] r_ras     [RAS_DEPTH];
   logic [c_ras_bits-1:0] r_ras_ptr;   // next slot to push into
   logic [c_ras_bits:0]   r_ras_cnt;
   logic [1:0]            w_hit_type;
   logic [1:0]            w_upd_type;
   logic [ADDR_WIDTH-1:0] w_ras_top;
   logic                  w_push;
   logic                  w_pop;

   assign w_hit_type = r_type[w_set][w_hit_way];
   assign w_upd_type = is_return_i ? c_type_return :
                       is_call_i   ? c_type_call   : c_type_branch;
   // Stale top is returned when empty because the pointer is left alone.
   assign w_ras_top  = r_ras[r_ras_ptr - c_ras_bits'(1)];
   assign w_push     = pred_valid_i && w_hit && (w_hit_type == c_type_call);
   assign w_pop      = pred_valid_i && w_hit && (w_hit_type == c_type_return);
`else
   logic w_unused_ras;
   assign w_unused_ras = is_call_i ^ is_return_i;
`endif

   always_comb begin
      w_taken  = w_hit && r_bht[w_bht_idx][1];
      w_target = w_taken ? r_target[w_set][w_hit_way] : w_pc_plus4;
`ifdef BP_RAS_EN
      if (w_hit && (w_hit_type == c_type_return)) begin
         w_taken  = 1'b1;
         w_target = w_ras_top;
      end
`endif
   end

   assign btb_hit_o          = w_hit;
   assign predict_taken_o    = w_taken;
   assign predict_target_o   = w_target;
   assign ghr_snapshot_o     = r_ghr;
   assign lookup_count_o     = r_lookup_cnt;
   assign mispredict_count_o = r_misp_cnt;

   // ------------------------------------------------------------------
   // Control state: valid bits, pointers, BHT, GHR, counters
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int s = 0; s < BTB_SETS; s++) begin
            for (int w = 0; w < BTB_WAYS; w++) r_valid[s][w] <= 1'b0;
            r_rr[s] <= '0;
         end
         for (int i = 0; i < BHT_ENTRIES; i++) r_bht[i] <= 2'b01;
         r_ghr        <= '0;
         r_lookup_cnt <= '0;
         r_misp_cnt   <= '0;
`ifdef BP_RAS_EN
         r_ras_ptr    <= '0;
         r_ras_cnt    <= '0;
`endif
      end else begin
         if (w_btb_write) r_valid[w_upd_set][w_upd_way] <= 1'b1;
         if (w_rr_advance) begin
            r_rr[w_upd_set] <= (r_rr[w_upd_set] == c_last_way) ? '0
                               : r_rr[w_upd_set] + c_way_bits'(1);
         end

         if (update_i) begin
            if (actual_taken_i && (r_bht[w_upd_bht_idx] != 2'b11))
               r_bht[w_upd_bht_idx] <= r_bht[w_upd_bht_idx] + 2'b01;
            else if (!actual_taken_i && (r_bht[w_upd_bht_idx] != 2'b00))
               r_bht[w_upd_bht_idx] <= r_bht[w_upd_bht_idx] - 2'b01;
         end

         // Repair wins over the speculative shift of the same cycle.
         if (update_i && mispredict_i)
            r_ghr <= {update_ghr_i[GHR_WIDTH-2:0], actual_taken_i};
         else if (pred_valid_i && w_hit)
            r_ghr <= {r_ghr[GHR_WIDTH-2:0], w_taken};

         if (pred_valid_i && (r_lookup_cnt != 32'hFFFF_FFFF))
            r_lookup_cnt <= r_lookup_cnt + 32'd1;
         if (update_i && mispredict_i && (r_misp_cnt != 32'hFFFF_FFFF))
            r_misp_cnt <= r_misp_cnt + 32'd1;

`ifdef BP_RAS_EN
         if (w_push) begin
            r_ras_ptr <= r_ras_ptr + c_ras_bits'(1);
            if (r_ras_cnt != (c_ras_bits + 1)'(RAS_DEPTH))
               r_ras_cnt <= r_ras_cnt + (c_ras_bits + 1)'(1);
         end else if (w_pop && (r_ras_cnt != '0)) begin
            r_ras_ptr <= r_ras_ptr - c_ras_bits'(1);
            r_ras_cnt <= r_ras_cnt - (c_ras_bits + 1)'(1);
         end
`endif
      end
   end

   // ------------------------------------------------------------------
   // Payload storage: qualified by valid bits, so it needs no reset.
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_ni && w_btb_write) begin
         r_tag[w_upd_set][w_upd_way]    <= w_upd_tag;
         r_target[w_upd_set][w_upd_way] <= actual_target_i;
`ifdef BP_RAS_EN
         r_type[w_upd_set][w_upd_way]   <= w_upd_type;
`endif
      end
`ifdef BP_RAS_EN
      if (rst_ni && w_push) r_ras[r_ras_ptr] <= w_pc_plus4;
`endif
   end

   // Low PC bits of the resolved instruction never index anything.
   logic w_unused_pc;
   assign w_unused_pc = ^update_pc_i[1:0];

`ifndef SYNTHESIS
   a_single_hit : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   $onehot0(w_hit_vec) && $onehot0(w_upd_hit_vec));
   a_misp_with_update : assert property (@(posedge clk_i) disable iff (!rst_ni)
                                         mispredict_i |-> update_i);
`endif

endmodule
`default_nettype wire

// File: tb/tb_gshare_btb_predictor.sv
`default_nettype none
module tb_gshare_btb_predictor;
   localparam int SETS = 32;
   localparam int WAYS = 2;
   localparam int BHT  = 256;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        pred_valid_i = 1'b0;
   logic [31:0] pc_i = '0;
   logic        predict_taken_o;
   logic [31:0] predict_target_o;
   logic        btb_hit_o;
   logic [7:0]  ghr_snapshot_o;
   logic        update_i = 1'b0;
   logic [31:0] update_pc_i = '0;
   logic [7:0]  update_ghr_i = '0;
   logic        actual_taken_i = 1'b0;
   logic [31:0] actual_target_i = '0;
   logic        mispredict_i = 1'b0;
   logic        is_call_i = 1'b0;
   logic        is_return_i = 1'b0;
   logic [31:0] lookup_count_o;
   logic [31:0] mispredict_count_o;

   int checks = 0;
   int failures = 0;

   always #5 clk_i = ~clk_i;

   gshare_btb_predictor dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .pred_valid_i(pred_valid_i), .pc_i(pc_i),
      .predict_taken_o(predict_taken_o), .predict_target_o(predict_target_o),
      .btb_hit_o(btb_hit_o), .ghr_snapshot_o(ghr_snapshot_o),
      .update_i(update_i), .update_pc_i(update_pc_i), .update_ghr_i(update_ghr_i),
      .actual_taken_i(actual_taken_i), .actual_target_i(actual_target_i),
      .mispredict_i(mispredict_i), .is_call_i(is_call_i), .is_return_i(is_return_i),
      .lookup_count_o(lookup_count_o), .mispredict_count_o(mispredict_count_o)
   );

   // Reference model: entries remembered by full word address, plain arithmetic.
   logic        m_valid [SETS][WAYS];
   logic [31:0] m_pc    [SETS][WAYS];
   logic [31:0] m_tgt   [SETS][WAYS];
   int          m_rr    [SETS];
   int          m_bht   [BHT];
   logic [31:0] m_ghr;
   logic [31:0] m_lookups;
   logic [31:0] m_misp;

   function automatic int set_of(input logic [31:0] pc);
      return int'((pc >> 2) % 32'(SETS));
   endfunction

   function automatic int idx_of(input logic [31:0] pc, input logic [31:0] g);
      return int'(((pc >> 2) % 32'(BHT)) ^ (g % 32'(BHT)));
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
         m_rr[s] = 0;
      end
      for (int i = 0; i < BHT; i++) m_bht[i] = 1;
      m_ghr = 0; m_lookups = 0; m_misp = 0;
   endfunction

   function automatic void model_predict(input logic [31:0] pc, output logic hit,
                                         output logic taken, output logic [31:0] tgt);
      int s;
      int way;
      s = set_of(pc);
      way = -1;
      for (int w = 0; w < WAYS; w++)
         if (m_valid[s][w] && ((m_pc[s][w] >> 2) == (pc >> 2))) way = w;
      hit = (way >= 0);
      taken = hit && (m_bht[idx_of(pc, m_ghr)] >= 2);
      tgt = pc + 32'd4;
      if (taken) tgt = m_tgt[s][way];
   endfunction

   function automatic void model_commit(input logic hit, input logic taken);
      int s;
      int way;
      int bi;
      if (pred_valid_i && m_lookups != 32'hFFFF_FFFF) m_lookups = m_lookups + 1;
      if (update_i && mispredict_i && m_misp != 32'hFFFF_FFFF) m_misp = m_misp + 1;
      if (update_i && mispredict_i)
         m_ghr = ((32'(update_ghr_i) << 1) | 32'(actual_taken_i)) % 256;
      else if (pred_valid_i && hit)
         m_ghr = ((m_ghr << 1) | 32'(taken)) % 256;
      if (update_i) begin
         bi = idx_of(update_pc_i, 32'(update_ghr_i));
         if (actual_taken_i) m_bht[bi] = (m_bht[bi] == 3) ? 3 : m_bht[bi] + 1;
         else                m_bht[bi] = (m_bht[bi] == 0) ? 0 : m_bht[bi] - 1;
         s = set_of(update_pc_i);
         way = -1;
         for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && ((m_pc[s][w] >> 2) == (update_pc_i >> 2))) way = w;
         if (way >= 0) begin
            m_tgt[s][way] = actual_target_i;
         end else if (actual_taken_i) begin
            for (int w = 0; w < WAYS; w++) if (way < 0 && !m_valid[s][w]) way = w;
            if (way < 0) begin
               way = m_rr[s];
               m_rr[s] = (m_rr[s] + 1) % WAYS;
            end
            m_valid[s][way] = 1'b1;
            m_pc[s][way]    = update_pc_i;
            m_tgt[s][way]   = actual_target_i;
         end
      end
   endfunction

   task automatic drive(input logic pv, input logic [31:0] pc, input logic upd,
                        input logic [31:0] upc, input logic [7:0] ughr, input logic at,
                        input logic [31:0] atgt, input logic mp);
      pred_valid_i = pv; pc_i = pc; update_i = upd; update_pc_i = upc;
      update_ghr_i = ughr; actual_taken_i = at; actual_target_i = atgt; mispredict_i = mp;
   endtask

   task automatic tick();
      logic h, t;
      logic [31:0] tg;
      model_predict(pc_i, h, t, tg);
      @(posedge clk_i);
      model_commit(h, t);
      #1;
   endtask

   task automatic apply_reset();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      is_call_i = 1'b0; is_return_i = 1'b0;
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      apply_reset();
      drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (btb_hit_o !== 1'b0) begin failures++; $display("FAIL reset_hit actual=%0h required=0", btb_hit_o); end
      checks++; if (predict_taken_o !== 1'b0) begin failures++; $display("FAIL reset_taken actual=%0h required=0", predict_taken_o); end
      checks++; if (predict_target_o !== 32'h104) begin failures++; $display("FAIL reset_target actual=%0h required=104", predict_target_o); end
      checks++; if (ghr_snapshot_o !== 8'h00) begin failures++; $display("FAIL reset_ghr actual=%0h required=0", ghr_snapshot_o); end
      checks++; if (lookup_count_o !== 32'd0) begin failures++; $display("FAIL reset_lookups actual=%0d required=0", lookup_count_o); end
      tick();
      drive(0, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0);
      #1;
      checks++; if (lookup_count_o !== 32'd1) begin failures++; $display("FAIL first_lookup_count actual=%0d required=1", lookup_count_o); end
      checks++; if (mispredict_count_o !== 32'd0) begin failures++; $display("FAIL reset_misp actual=%0d required=0", mispredict_count_o); end
      checks++; if (predict_target_o !== 32'h0) begin failures++; $display("FAIL pc_wrap actual=%0h required=0", predict_target_o); end
   endtask

   task automatic test_eviction();
      drive(0, 0, 1, 32'h1000, 0, 1, 32'h2000, 0); tick();
      drive(0, 0, 1, 32'h1080, 0, 1, 32'h2080, 0); tick();
      drive(0, 0, 1, 32'h1100, 0, 1, 32'h2100, 0); tick();
      drive(0, 32'h1000, 0, 0, 0, 0, 0, 0); #1;
      checks++; if (btb_hit_o !== 1'b0) begin failures++; $display("FAIL evict_1000_hit actual=%0h required=0", btb_hit_o); end
      pc_i = 32'h1080; #1;
      checks++; if (btb_hit_o !== 1'b1) begin failures++; $display("FAIL evict_1080_hit actual=%0h required=1", btb_hit_o); end
      checks++; if (predict_target_o !== 32'h2080) begin failures++; $display("FAIL evict_1080_target actual=%0h required=2080", predict_target_o); end
      pc_i = 32'h1100; #1;
      checks++; if (btb_hit_o !== 1'b1) begin failures++; $display("FAIL evict_1100_hit actual=%0h required=1", btb_hit_o); end
      checks++; if (predict_target_o !== 32'h2100) begin failures++; $display("FAIL evict_1100_target actual=%0h required=2100", predict_target_o); end
   endtask

   task automatic test_mid_reset();
      drive(1, 32'h1080, 1, 32'h1000, 0, 1, 32'h3000, 0);
      #2 rst_ni = 1'b0;
      #1;
      checks++; if (btb_hit_o !== 1'b0) begin failures++; $display("FAIL midrst_hit actual=%0h required=0", btb_hit_o); end
      checks++; if (predict_target_o !== 32'h1084) begin failures++; $display("FAIL midrst_target actual=%0h required=1084", predict_target_o); end
      checks++; if (lookup_count_o !== 32'd0) begin failures++; $display("FAIL midrst_lookups actual=%0d required=0", lookup_count_o); end
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      model_reset();
      drive(0, 32'h1000, 0, 0, 0, 0, 0, 0); #1;
      checks++; if (btb_hit_o !== 1'b0) begin failures++; $display("FAIL midrst_no_update actual=%0h required=0", btb_hit_o); end
      pc_i = 32'h1100; #1;
      checks++; if (btb_hit_o !== 1'b0) begin failures++; $display("FAIL midrst_cleared actual=%0h required=0", btb_hit_o); end
      checks++; if (ghr_snapshot_o !== 8'h00) begin failures++; $display("FAIL midrst_ghr actual=%0h required=0", ghr_snapshot_o); end
   endtask

   task automatic test_train();
      repeat (3) begin drive(0, 0, 1, 32'h200, 0, 1, 32'h400, 0); tick(); end
      drive(0, 32'h200, 0, 0, 0, 0, 0, 0); #1;
      checks++; if (btb_hit_o !== 1'b1) begin failures++; $display("FAIL train_hit actual=%0h required=1", btb_hit_o); end
      checks++; if (predict_taken_o !== 1'b1) begin failures++; $display("FAIL train_taken actual=%0h required=1", predict_taken_o); end
      checks++; if (predict_target_o !== 32'h400) begin failures++; $display("FAIL train_target actual=%0h required=400", predict_target_o); end
      repeat (2) begin drive(0, 0, 1, 32'h200, 8'h01, 1, 32'h400, 0); tick(); end
   endtask

   task automatic test_same_cycle();
      drive(1, 32'h200, 1, 32'h200, 8'h02, 1, 32'h800, 0); #1;
      checks++; if (btb_hit_o !== 1'b1) begin failures++; $display("FAIL same_hit actual=%0h required=1", btb_hit_o); end
      checks++; if (predict_target_o !== 32'h400) begin failures++; $display("FAIL same_old_target actual=%0h required=400", predict_target_o); end
      tick();
      drive(1, 32'h200, 0, 0, 0, 0, 0, 0); #1;
      checks++; if (ghr_snapshot_o !== 8'h01) begin failures++; $display("FAIL spec_ghr1 actual=%0h required=1", ghr_snapshot_o); end
      checks++; if (predict_taken_o !== 1'b1) begin failures++; $display("FAIL same_taken actual=%0h required=1", predict_taken_o); end
      checks++; if (predict_target_o !== 32'h800) begin failures++; $display("FAIL same_new_target actual=%0h required=800", predict_target_o); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
      checks++; if (ghr_snapshot_o !== 8'h03) begin failures++; $display("FAIL spec_ghr3 actual=%0h required=3", ghr_snapshot_o); end
   endtask

   task automatic test_ghr_repair();
      drive(1, 32'h200, 1, 32'h200, 8'h05, 0, 32'h800, 1); #1;
      checks++; if (btb_hit_o !== 1'b1) begin failures++; $display("FAIL repair_hit actual=%0h required=1", btb_hit_o); end
      checks++; if (predict_taken_o !== 1'b0) begin failures++; $display("FAIL repair_pre_taken actual=%0h required=0", predict_taken_o); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0, 0); #1;
      checks++; if (ghr_snapshot_o !== 8'h0A) begin failures++; $display("FAIL repair_ghr actual=%0h required=a", ghr_snapshot_o); end
      checks++; if (mispredict_count_o !== 32'd1) begin failures++; $display("FAIL repair_misp_count actual=%0d required=1", mispredict_count_o); end
      checks++; if (lookup_count_o !== 32'd3) begin failures++; $display("FAIL repair_lookup_count actual=%0d required=3", lookup_count_o); end
   endtask

   function automatic logic [31:0] pick_pc();
      if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC;
      return 32'h1000 + (32'($urandom_range(0, 7)) << 7) + (32'($urandom_range(0, 3)) << 2);
   endfunction

   task automatic test_random();
      logic h, t, upd;
      logic [31:0] tg;
      for (int n = 0; n < 400; n++) begin
         upd = ($urandom_range(0, 2) == 0);
         drive(1'($urandom_range(0, 1)), pick_pc(), upd, pick_pc(), 8'($urandom),
               1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
               upd && ($urandom_range(0, 3) == 0));
         #1;
         model_predict(pc_i, h, t, tg);
         checks++; if (btb_hit_o !== h) begin failures++; $display("FAIL rnd_hit n=%0d pc=%0h actual=%0h required=%0h", n, pc_i, btb_hit_o, h); end
         checks++; if (predict_taken_o !== t) begin failures++; $display("FAIL rnd_taken n=%0d pc=%0h actual=%0h required=%0h", n, pc_i, predict_taken_o, t); end
         checks++; if (predict_target_o !== tg) begin failures++; $display("FAIL rnd_target n=%0d pc=%0h actual=%0h required=%0h", n, pc_i, predict_target_o, tg); end
         checks++; if (ghr_snapshot_o !== m_ghr[7:0]) begin failures++; $display("FAIL rnd_ghr n=%0d actual=%0h required=%0h", n, ghr_snapshot_o, m_ghr[7:0]); end
         checks++; if (lookup_count_o !== m_lookups) begin failures++; $display("FAIL rnd_lookups n=%0d actual=%0d required=%0d", n, lookup_count_o, m_lookups); end
         checks++; if (mispredict_count_o !== m_misp) begin failures++; $display("FAIL rnd_misp n=%0d actual=%0d required=%0d", n, mispredict_count_o, m_misp); end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

`ifdef BP_RAS_EN
   task automatic test_ras();
      apply_reset();
      is_call_i = 1'b1;
      for (int k = 0; k < 9; k++) begin
         drive(0, 0, 1, 32'h300 + 32'(4 * k), 0, 1, 32'h700, 0); tick();
      end
      is_call_i = 1'b0; is_return_i = 1'b1;
      drive(0, 0, 1, 32'h500, 0, 1, 32'h900, 0); tick();
      is_return_i = 1'b0;
      drive(1, 32'h300, 0, 0, 0, 0, 0, 0); tick();
      drive(1, 32'h500, 0, 0, 0, 0, 0, 0); #1;
      checks++; if (predict_taken_o !== 1'b1) begin failures++; $display("FAIL ras_ret_taken actual=%0h required=1", predict_taken_o); end
      checks++; if (predict_target_o !== 32'h304) begin failures++; $display("FAIL ras_ret_target actual=%0h required=304", predict_target_o); end
      tick();
      for (int k = 0; k < 9; k++) begin
         drive(1, 32'h300 + 32'(4 * k), 0, 0, 0, 0, 0, 0); tick();
      end
      for (int i = 0; i < 8; i++) begin
         drive(1, 32'h500, 0, 0, 0, 0, 0, 0); #1;
         checks++; if (predict_target_o !== 32'h324 - 32'(4 * i)) begin failures++; $display("FAIL ras_pop i=%0d actual=%0h required=%0h", i, predict_target_o, 32'h324 - 32'(4 * i)); end
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask
`endif

   initial begin
      test_reset();
      test_eviction();
      test_mid_reset();
      test_train();
      test_same_cycle();
      test_ghr_repair();
      test_random();
`ifdef BP_RAS_EN
      test_ras();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
